// File: rtl/bf_run_decode_if.sv
// Fetch-side byte handshake and execute-side operation handshake of bf_run_decode.
// master drives bytes/flush/op_ack_in; slave is the decode stage.
interface bf_run_decode_if #(
  parameter int COUNT_W = 8
);
  logic [7:0]         opcode_in;
  logic               opcode_valid;
  logic               opcode_ack;
  logic               flush;
  logic [7:0]         operation;
  logic [COUNT_W-1:0] count;
  logic               op_valid;
  logic               op_ack_in;

  modport master (
    output opcode_in, opcode_valid, flush, op_ack_in,
    input  opcode_ack, operation, count, op_valid
  );

  modport slave (
    input  opcode_in, opcode_valid, flush, op_ack_in,
    output opcode_ack, operation, count, op_valid
  );
endinterface

// File: rtl/bf_run_decode.sv
// Decode stage folding runs of > < + - into one-hot op + count; RUN_FOLD_EN enables folding.
// Latency: single op accepted at t is valid at t+2; a run is valid the cycle after it closes.
// Backpressure: with output full and held, only comments and same-op run extensions are acked.
module bf_run_decode #(
  parameter int COUNT_W = 8
) (
  input logic           clk,
  input logic           reset_n,
  bf_run_decode_if.slave bus
);

  localparam logic [COUNT_W-1:0] CNT_ONE = COUNT_W'(1);
  localparam logic [COUNT_W-1:0] CNT_MAX = {COUNT_W{1'b1}};

  logic [7:0]         in_oh;
  logic               in_fold;
  logic               in_comment;
  logic               load_closed;
  logic               extend;
  logic               out_free;
  logic               take;
  logic               push;

  logic [7:0]         acc_op_q, acc_op_d;
  logic [COUNT_W-1:0] acc_cnt_q, acc_cnt_d;
  logic               acc_valid_q, acc_valid_d;
  logic               acc_closed_q, acc_closed_d;
  logic [7:0]         op_q, op_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;
  logic               op_valid_q, op_valid_d;

  always_comb begin
    in_oh = 8'h00;
    case (bus.opcode_in)
      8'h3E:   in_oh = 8'h01;
      8'h3C:   in_oh = 8'h02;
      8'h2B:   in_oh = 8'h04;
      8'h2D:   in_oh = 8'h08;
      8'h2E:   in_oh = 8'h10;
      8'h2C:   in_oh = 8'h20;
      8'h5B:   in_oh = 8'h40;
      8'h5D:   in_oh = 8'h80;
      default: in_oh = 8'h00;
    endcase
  end

  assign in_fold    = |in_oh[3:0];
  assign in_comment = ~|in_oh;
  assign out_free   = !op_valid_q || bus.op_ack_in;

`ifdef RUN_FOLD_EN
  assign extend      = acc_valid_q && !acc_closed_q && in_fold && (in_oh == acc_op_q);
  assign load_closed = !in_fold;
`else
  // Without folding every real byte is a closed run of one.
  assign extend      = 1'b0;
  assign load_closed = 1'b1;
`endif

  assign bus.opcode_ack = !bus.flush &&
                          (in_comment || !acc_valid_q || out_free || extend);
  assign take           = bus.opcode_valid && bus.opcode_ack;

  always_comb begin
    acc_op_d     = acc_op_q;
    acc_cnt_d    = acc_cnt_q;
    acc_valid_d  = acc_valid_q;
    acc_closed_d = acc_closed_q;
    op_d         = op_q;
    cnt_d        = cnt_q;
    op_valid_d   = op_valid_q;
    push         = 1'b0;

    if (take && extend) begin
      acc_cnt_d = acc_cnt_q + CNT_ONE;
      if (acc_cnt_q == CNT_MAX - CNT_ONE) begin
        acc_closed_d = 1'b1;
      end
    end else if (take && !in_comment) begin
      // A new real byte always evicts the accumulator; ack guarantees out_free here.
      push         = acc_valid_q;
      acc_op_d     = in_oh;
      acc_cnt_d    = CNT_ONE;
      acc_valid_d  = 1'b1;
      acc_closed_d = load_closed;
    end else if (acc_valid_q && out_free && (acc_closed_q || bus.flush)) begin
      push        = 1'b1;
      acc_valid_d = 1'b0;
    end

    if (push) begin
      op_d       = acc_op_q;
      cnt_d      = acc_cnt_q;
      op_valid_d = 1'b1;
    end else if (bus.op_ack_in) begin
      op_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_op_q     <= 8'h00;
      acc_cnt_q    <= '0;
      acc_valid_q  <= 1'b0;
      acc_closed_q <= 1'b0;
      op_q         <= 8'h00;
      cnt_q        <= '0;
      op_valid_q   <= 1'b0;
    end else begin
      acc_op_q     <= acc_op_d;
      acc_cnt_q    <= acc_cnt_d;
      acc_valid_q  <= acc_valid_d;
      acc_closed_q <= acc_closed_d;
      op_q         <= op_d;
      cnt_q        <= cnt_d;
      op_valid_q   <= op_valid_d;
    end
  end

  assign bus.operation = op_q;
  assign bus.count     = cnt_q;
  assign bus.op_valid  = op_valid_q;

endmodule

// File: tb/tb_bf_run_decode.sv
// Bench for bf_run_decode: directed run-folding scenarios plus randomized traffic against a byte-level model.
module tb_bf_run_decode;
  localparam int CW   = 8;
  localparam int MAXC = (1 << CW) - 1;
`ifdef RUN_FOLD_EN
  localparam bit FOLD = 1'b1;
`else
  localparam bit FOLD = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  bf_run_decode_if #(.COUNT_W(CW)) bus ();

  bf_run_decode #(.COUNT_W(CW)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit rand_ack  = 1'b0;
  bit fixed_ack = 1'b1;
  bit chk_en    = 1'b0;

  // Model: the open run (character + length) and the one-entry output slot.
  bit         m_acc_v = 1'b0;
  bit         m_acc_closed = 1'b0;
  logic [7:0] m_acc_ch = 8'h00;
  int         m_acc_n = 0;
  bit         m_out_v = 1'b0;
  logic [7:0] m_out_ch = 8'h00;
  int         m_out_n = 0;
  logic [7:0] got_ch[$];
  int         got_n[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] kind(input logic [7:0] b);
    case (b)
      ">", "<", "+", "-": return 2'd1;
      ".", ",", "[", "]": return 2'd2;
      default:            return 2'd0;
    endcase
  endfunction

  function automatic logic [7:0] onehot(input logic [7:0] b);
    case (b)
      ">": return 8'h01;
      "<": return 8'h02;
      "+": return 8'h04;
      "-": return 8'h08;
      ".": return 8'h10;
      ",": return 8'h20;
      "[": return 8'h40;
      "]": return 8'h80;
      default: return 8'h00;
    endcase
  endfunction

  function automatic bit model_same();
    return FOLD && m_acc_v && !m_acc_closed && kind(bus.opcode_in) == 2'd1 &&
           bus.opcode_in == m_acc_ch;
  endfunction

  function automatic bit exp_ack();
    return !bus.flush && (kind(bus.opcode_in) == 2'd0 || !m_acc_v || !m_out_v ||
                          bus.op_ack_in || model_same());
  endfunction

  always begin
    bus.op_ack_in = rand_ack ? ($urandom_range(0, 3) != 0) : fixed_ack;
    @(posedge clk);
    #1;
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_acc_v = 1'b0;
      m_acc_closed = 1'b0;
      m_acc_n = 0;
      m_out_v = 1'b0;
    end else begin : step
      bit take, same, free;
      logic [1:0] k;
      k    = kind(bus.opcode_in);
      free = !m_out_v || bus.op_ack_in;
      take = bus.opcode_valid && exp_ack();
      same = model_same();
      if (m_out_v && bus.op_ack_in) begin
        got_ch.push_back(m_out_ch);
        got_n.push_back(m_out_n);
        m_out_v = 1'b0;
      end
      if (take && same) begin
        m_acc_n++;
        if (m_acc_n == MAXC) m_acc_closed = 1'b1;
      end else if (take && k != 2'd0) begin
        if (m_acc_v) begin
          m_out_v = 1'b1; m_out_ch = m_acc_ch; m_out_n = m_acc_n;
        end
        m_acc_v = 1'b1; m_acc_ch = bus.opcode_in; m_acc_n = 1;
        m_acc_closed = (k == 2'd2) || !FOLD;
      end else if (m_acc_v && free && (m_acc_closed || bus.flush)) begin
        m_out_v = 1'b1; m_out_ch = m_acc_ch; m_out_n = m_acc_n;
        m_acc_v = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n && chk_en) begin
      chk("opcode_ack", 32'(bus.opcode_ack), 32'(exp_ack()));
      chk("op_valid", 32'(bus.op_valid), 32'(m_out_v));
      if (m_out_v) begin
        chk("operation", 32'(bus.operation), 32'(onehot(m_out_ch)));
        chk("count", 32'(bus.count), 32'(m_out_n));
      end
    end
  end

  // Holds a byte until the handshake completes; returns at posedge+1.
  task automatic send(input logic [7:0] b);
    bit ok = 1'b0;
    bus.opcode_in = b;
    bus.opcode_valid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = bus.opcode_ack;
      @(posedge clk);
      #1;
    end
    bus.opcode_valid = 1'b0;
    if (!ok) chk("send_timeout", 32'(0), 32'(1));
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic drain();
    bit done = 1'b0;
    bus.flush = 1'b1;
    for (int i = 0; i < 400 && !done; i++) begin
      @(posedge clk);
      #1;
      if (!m_acc_v) bus.flush = 1'b0;
      done = !m_acc_v && !m_out_v;
    end
    bus.flush = 1'b0;
    if (!done) chk("drain_timeout", 32'(0), 32'(1));
  endtask

  task automatic clear_got();
    got_ch.delete();
    got_n.delete();
  endtask

  task automatic expect_got(input int idx, input logic [7:0] ch, input int n);
    if (idx < got_ch.size()) begin
      chk($sformatf("seq[%0d].op", idx), 32'(got_ch[idx]), 32'(ch));
      chk($sformatf("seq[%0d].cnt", idx), 32'(got_n[idx]), 32'(n));
    end else begin
      chk($sformatf("seq[%0d].present", idx), 32'(0), 32'(1));
    end
  endtask

  logic [7:0] alph [11] = '{">", "<", "+", "-", ".", ",", "[", "]", "a", " ", "x"};

  initial begin
    logic [7:0] prev;
    bus.opcode_in = 8'h00;
    bus.opcode_valid = 1'b0;
    bus.flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_op_valid", 32'(bus.op_valid), 32'(0));
    chk("rst_operation", 32'(bus.operation), 32'(0));
    chk("rst_count", 32'(bus.count), 32'(0));
    chk("rst_ack", 32'(bus.opcode_ack), 32'(1));
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk_en = 1'b1;

    fixed_ack = 1'b1;
    clear_got();
    send_str("+++>");
    drain();
`ifdef RUN_FOLD_EN
    chk("seq1_len", 32'(got_ch.size()), 32'(2));
    expect_got(0, "+", 3);
    expect_got(1, ">", 1);
`else
    chk("seq1_len", 32'(got_ch.size()), 32'(4));
    expect_got(0, "+", 1);
    expect_got(3, ">", 1);
`endif
    chk("idle_op_valid", 32'(bus.op_valid), 32'(0));

    clear_got();
    send_str("+a +[[");
    drain();
`ifdef RUN_FOLD_EN
    chk("seq2_len", 32'(got_ch.size()), 32'(3));
    expect_got(0, "+", 2);
    expect_got(1, "[", 1);
    expect_got(2, "[", 1);
`else
    chk("seq2_len", 32'(got_ch.size()), 32'(4));
    expect_got(1, "+", 1);
    expect_got(2, "[", 1);
`endif

    clear_got();
    send_str("++.");
    drain();
`ifdef RUN_FOLD_EN
    expect_got(0, "+", 2);
    expect_got(1, ".", 1);
`else
    chk("seq3_len", 32'(got_ch.size()), 32'(3));
    expect_got(0, "+", 1);
    expect_got(1, "+", 1);
    expect_got(2, ".", 1);
`endif

    clear_got();
    for (int i = 0; i < MAXC + 1; i++) send("+");
    drain();
`ifdef RUN_FOLD_EN
    chk("sat_len", 32'(got_ch.size()), 32'(2));
    expect_got(0, "+", MAXC);
    expect_got(1, "+", 1);
`else
    chk("sat_len", 32'(got_ch.size()), 32'(MAXC + 1));
`endif

    // Output held by execute: only same-op extensions get through.
    clear_got();
    send(".");
    fixed_ack = 1'b0;
    send("-");
`ifdef RUN_FOLD_EN
    send("-");
    bus.opcode_in = ">";
`else
    bus.opcode_in = "-";
`endif
    bus.opcode_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("bp_ack_low", 32'(bus.opcode_ack), 32'(0));
      chk("bp_operation", 32'(bus.operation), 32'(8'h10));
      chk("bp_count", 32'(bus.count), 32'(1));
    end
    @(posedge clk);
    #1;
    fixed_ack = 1'b1;
    send(bus.opcode_in);
    drain();
`ifdef RUN_FOLD_EN
    chk("bp_len", 32'(got_ch.size()), 32'(3));
    expect_got(1, "-", 2);
    expect_got(2, ">", 1);
`else
    chk("bp_len", 32'(got_ch.size()), 32'(3));
    expect_got(1, "-", 1);
    expect_got(2, "-", 1);
`endif
    expect_got(0, ".", 1);

    send_str("+++++");
`ifdef RUN_FOLD_EN
    chk("model_run5", 32'(m_acc_n), 32'(5));
`endif
    reset_n = 1'b0;
    #1;
    chk("mid_rst_op_valid", 32'(bus.op_valid), 32'(0));
    chk("mid_rst_operation", 32'(bus.operation), 32'(0));
    chk("mid_rst_count", 32'(bus.count), 32'(0));
    chk("mid_rst_ack", 32'(bus.opcode_ack), 32'(1));
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    clear_got();
    bus.flush = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    bus.flush = 1'b0;
    chk("post_rst_no_emit", 32'(got_ch.size()), 32'(0));
    chk("post_rst_op_valid", 32'(bus.op_valid), 32'(0));

    rand_ack = 1'b1;
    prev = "+";
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 1) == 0) prev = alph[$urandom_range(0, 10)];
      send(prev);
      if ($urandom_range(0, 15) == 0) begin
        bus.flush = 1'b1;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
        bus.flush = 1'b0;
      end
      if ($urandom_range(0, 7) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    drain();

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
